morph_frame_ctrl: RTL
=====================

MORPH_FRAME_CTRL -- requirements
Module: morph_frame_ctrl

Interface
REQ-001 SHALL have parameter IMG_W, default 640: pixels per line (>=3).
REQ-002 SHALL have parameter IMG_H, default 480: lines per frame (>=3).
REQ-003 SHALL have parameter PIPE_LAT, default 2: cycles from a window shift to the filter result register (>=1).
REQ-004 SHALL have port clk, input, 1: clock; all logic is on the rising edge.
REQ-005 SHALL have port rstn, input, 1: reset, asynchronous, active-low.
REQ-006 SHALL have port start, input, 1: single-cycle frame start request.
REQ-007 SHALL have port abort, input, 1: synchronous frame cancel.
REQ-008 SHALL have port in_valid, input, 1: upstream pixel present.
REQ-009 SHALL have port in_ready, output, 1: controller accepts a pixel this cycle.
REQ-010 SHALL have port lb_clken, output, 1: line-buffer/window shift enable.
REQ-011 SHALL have port pad_sel, output, 1: 1 selects the pad value instead of input_data into the window.
REQ-012 SHALL have port out_valid, output, 1: filter output is a real frame pixel.
REQ-013 SHALL have port out_border, output, 1: the current output pixel lies on the frame edge.
REQ-014 SHALL have ports out_row and out_col, outputs, clog2(IMG_H) and clog2(IMG_W) bits: coordinates of the output pixel.
REQ-015 SHALL have ports busy, done and start_err, outputs, 1 each: frame in progress, frame-complete pulse, and start-while-busy pulse.

Function
REQ-016 SHALL implement the states IDLE, RUN, FLUSH, DRAIN and DONE.
REQ-017 IDLE SHALL go to RUN on start=1; in IDLE, in_ready, lb_clken and busy SHALL be 0.
REQ-018 In RUN, in_ready SHALL be 1 and lb_clken SHALL equal in_valid, with pad_sel=0; a shift occurs on every cycle with lb_clken=1.
REQ-019 RUN SHALL go to FLUSH on the accepted shift that brings the input count to IMG_W*IMG_H.
REQ-020 In FLUSH, in_ready SHALL be 0 and lb_clken and pad_sel SHALL both be 1 for exactly IMG_W+1 cycles; FLUSH SHALL then go to DRAIN.
REQ-021 DRAIN SHALL hold lb_clken=0 for PIPE_LAT cycles and SHALL then go to DONE.
REQ-022 DONE SHALL last one cycle with done=1 and SHALL then return to IDLE.
REQ-023 busy SHALL be 1 in RUN, FLUSH, DRAIN and DONE.
REQ-024 Shifts SHALL be numbered s = 0 .. IMG_W*IMG_H+IMG_W, counting both RUN and FLUSH shifts; the window centre index of shift s SHALL be c = s-(IMG_W+1).
REQ-025 For every shift with c>=0, out_valid SHALL be 1 exactly PIPE_LAT cycles after that shift's clock edge, with out_row = c/IMG_W and out_col = c mod IMG_W.
REQ-026 out_valid SHALL be 0 in all other cycles, giving exactly IMG_W*IMG_H out_valid cycles per frame.
REQ-027 out_border SHALL equal out_valid AND (out_row==0 OR out_row==IMG_H-1 OR out_col==0 OR out_col==IMG_W-1).
REQ-028 Column counters SHALL wrap IMG_W-1 -> 0 and increment the row counter at the wrap.
REQ-029 A stall (in_valid=0 in RUN) SHALL freeze all counters; the out_valid delay line SHALL advance every cycle regardless of the stall.
REQ-030 start while busy=1 SHALL be ignored and SHALL pulse start_err for one cycle.
REQ-031 abort=1 SHALL force IDLE on the next edge, clear the counters and the valid pipeline, and suppress done; abort SHALL have priority over start in the same cycle.
REQ-032 start in the DONE cycle SHALL count as busy and pulse start_err.

Reset
REQ-033 rstn=0 SHALL asynchronously force IDLE, zero all counters and the delay line, and drive every output to 0.
REQ-034 Reset asserted mid-frame SHALL discard the frame with no done pulse; the first frame after reset SHALL require a new start.

Structure
REQ-035 The state encoding and the clog2-derived counter widths SHALL live in a shared package, morph_pkg.
REQ-036 A single sub-module, valid_delay_line (PIPE_LAT-deep shift register carrying valid, row and col), SHALL be instantiated.

Verification (IMG_W=4, IMG_H=3, PIPE_LAT=2)
REQ-037 start, then in_valid held at 1 for 12 cycles -> exactly 17 lb_clken cycles, the last 5 with pad_sel=1; the first out_valid comes 2 cycles after the shift with s=5; exactly 12 out_valid cycles; done pulses once, one cycle after the last out_valid.
REQ-038 Full frame -> out_border=0 only at (row,col) = (1,1) and (1,2); all other valid pixels have out_border=1.
REQ-039 in_valid toggling 1/0 every cycle -> 12 accepted pixels, coordinates strictly raster-ordered, no duplicate or missing (row,col).
REQ-040 start pulsed during RUN -> start_err=1 for one cycle, and the frame output is identical to REQ-037.
REQ-041 abort after 7 accepted pixels -> IDLE next cycle, out_valid=0 from the following cycle, no done; a subsequent start yields a clean REQ-037 sequence.
REQ-042 rstn pulsed low during FLUSH -> all outputs 0 immediately, state IDLE, and no done after rstn rises.

Source files
------------

// File: rtl/morph_pkg.sv
// Shared types and width helpers for the morphology frame controller.
// Counter widths are derived from image geometry through cnt_w().
package morph_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_RUN   = 3'd1,
      ST_FLUSH = 3'd2,
      ST_DRAIN = 3'd3,
      ST_DONE  = 3'd4
   } state_t;

   localparam int unsigned IMG_W_DEF    = 640;
   localparam int unsigned IMG_H_DEF    = 480;
   localparam int unsigned PIPE_LAT_DEF = 2;

   // Bits needed to hold values 0 .. n-1, never less than one.
   function automatic int unsigned cnt_w(input int unsigned n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction

   localparam int unsigned COL_W_DEF = cnt_w(IMG_W_DEF);
   localparam int unsigned ROW_W_DEF = cnt_w(IMG_H_DEF);

endpackage

// File: rtl/valid_delay_line.sv
// Fixed-depth shift register that carries the output-pixel valid flag and its
// coordinates alongside the filter pipeline; it advances every cycle.
module valid_delay_line #(
   parameter int unsigned DEPTH = 2,
   parameter int unsigned RW    = 2,
   parameter int unsigned CW    = 2
) (
   input  logic          clk,
   input  logic          rstn,
   input  logic          i_clr,
   input  logic          i_valid,
   input  logic [RW-1:0] i_row,
   input  logic [CW-1:0] i_col,
   output logic          o_valid,
   output logic [RW-1:0] o_row,
   output logic [CW-1:0] o_col
);

   logic [DEPTH-1:0] r_valid;
   logic [RW-1:0]    r_row [DEPTH];
   logic [CW-1:0]    r_col [DEPTH];

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_valid <= '0;
         for (int unsigned i = 0; i < DEPTH; i++) begin
            r_row[i] <= '0;
            r_col[i] <= '0;
         end
      end else if (i_clr) begin
         r_valid <= '0;
         for (int unsigned i = 0; i < DEPTH; i++) begin
            r_row[i] <= '0;
            r_col[i] <= '0;
         end
      end else begin
         r_valid[0] <= i_valid;
         r_row[0]   <= i_row;
         r_col[0]   <= i_col;
         for (int unsigned i = 1; i < DEPTH; i++) begin
            r_valid[i] <= r_valid[i-1];
            r_row[i]   <= r_row[i-1];
            r_col[i]   <= r_col[i-1];
         end
      end
   end

   assign o_valid = r_valid[DEPTH-1];
   assign o_row   = r_row[DEPTH-1];
   assign o_col   = r_col[DEPTH-1];

endmodule

// File: rtl/morph_frame_ctrl.sv
// Frame sequencer for a 3x3 morphology window: accepts IMG_W*IMG_H pixels,
// flushes the line buffers with padding and tags each filter output.
module morph_frame_ctrl
   import morph_pkg::*;
#(
   parameter int unsigned IMG_W    = IMG_W_DEF,
   parameter int unsigned IMG_H    = IMG_H_DEF,
   parameter int unsigned PIPE_LAT = PIPE_LAT_DEF
) (
   input  logic                      clk,
   input  logic                      rstn,
   input  logic                      start,
   input  logic                      abort,
   input  logic                      in_valid,
   output logic                      in_ready,
   output logic                      lb_clken,
   output logic                      pad_sel,
   output logic                      out_valid,
   output logic                      out_border,
   output logic [cnt_w(IMG_H)-1:0]   out_row,
   output logic [cnt_w(IMG_W)-1:0]   out_col,
   output logic                      busy,
   output logic                      done,
   output logic                      start_err
);

   localparam int unsigned RW   = cnt_w(IMG_H);
   localparam int unsigned CW   = cnt_w(IMG_W);
   localparam int unsigned NPIX = IMG_W * IMG_H;
   localparam int unsigned IW   = cnt_w(NPIX + 1);
   localparam int unsigned FW   = cnt_w(IMG_W + 2);
   localparam int unsigned DW   = cnt_w(PIPE_LAT + 1);

   state_t        r_state;
   state_t        w_nxt;
   logic [IW-1:0] r_in_cnt;
   logic [FW-1:0] r_flush_cnt;
   logic [FW-1:0] r_warm;
   logic [DW-1:0] r_drain_cnt;
   logic [RW-1:0] r_crow;
   logic [CW-1:0] r_ccol;
   logic          w_cvalid;
   logic          w_clr;
   logic          w_dl_valid;
   logic [RW-1:0] w_dl_row;
   logic [CW-1:0] w_dl_col;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) r_state <= ST_IDLE;
      else       r_state <= w_nxt;
   end

   always_comb begin
      w_nxt = r_state;
      if (abort) begin
         w_nxt = ST_IDLE;
      end else begin
         case (r_state)
            ST_IDLE:  if (start) w_nxt = ST_RUN;
            ST_RUN:   if (in_valid && r_in_cnt == IW'(NPIX - 1)) w_nxt = ST_FLUSH;
            ST_FLUSH: if (r_flush_cnt == FW'(IMG_W)) w_nxt = ST_DRAIN;
            ST_DRAIN: if (r_drain_cnt == DW'(PIPE_LAT - 1)) w_nxt = ST_DONE;
            ST_DONE:  w_nxt = ST_IDLE;
            default:  w_nxt = ST_IDLE;
         endcase
      end
   end

   always_comb begin
      in_ready = 1'b0;
      lb_clken = 1'b0;
      pad_sel  = 1'b0;
      busy     = 1'b0;
      done     = 1'b0;
      case (r_state)
         ST_RUN: begin
            in_ready = 1'b1;
            lb_clken = in_valid;
            busy     = 1'b1;
         end
         ST_FLUSH: begin
            lb_clken = 1'b1;
            pad_sel  = 1'b1;
            busy     = 1'b1;
         end
         ST_DRAIN: busy = 1'b1;
         ST_DONE: begin
            busy = 1'b1;
            done = 1'b1;
         end
         default: ;
      endcase
   end

   assign start_err = start & busy;

   // The first IMG_W+1 shifts only prime the window; centre coordinates
   // start counting once r_warm saturates.
   assign w_cvalid = (r_warm == FW'(IMG_W + 1));
   assign w_clr    = abort || (r_state == ST_IDLE);

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_in_cnt    <= '0;
         r_flush_cnt <= '0;
         r_warm      <= '0;
         r_drain_cnt <= '0;
         r_crow      <= '0;
         r_ccol      <= '0;
      end else if (w_clr) begin
         r_in_cnt    <= '0;
         r_flush_cnt <= '0;
         r_warm      <= '0;
         r_drain_cnt <= '0;
         r_crow      <= '0;
         r_ccol      <= '0;
      end else begin
         if (lb_clken) begin
            if (r_state == ST_RUN) r_in_cnt <= r_in_cnt + 1'b1;
            if (!w_cvalid) begin
               r_warm <= r_warm + 1'b1;
            end else if (r_ccol == CW'(IMG_W - 1)) begin
               r_ccol <= '0;
               r_crow <= (r_crow == RW'(IMG_H - 1)) ? '0 : r_crow + 1'b1;
            end else begin
               r_ccol <= r_ccol + 1'b1;
            end
         end
         if (r_state == ST_FLUSH) r_flush_cnt <= r_flush_cnt + 1'b1;
         if (r_state == ST_DRAIN) r_drain_cnt <= r_drain_cnt + 1'b1;
      end
   end

   // Zero the coordinates of non-valid slots so idle outputs read as 0.
   assign w_dl_valid = lb_clken & w_cvalid;
   assign w_dl_row   = w_dl_valid ? r_crow : '0;
   assign w_dl_col   = w_dl_valid ? r_ccol : '0;

   valid_delay_line #(
      .DEPTH (PIPE_LAT),
      .RW    (RW),
      .CW    (CW)
   ) u_valid_dly (
      .clk     (clk),
      .rstn    (rstn),
      .i_clr   (abort),
      .i_valid (w_dl_valid),
      .i_row   (w_dl_row),
      .i_col   (w_dl_col),
      .o_valid (out_valid),
      .o_row   (out_row),
      .o_col   (out_col)
   );

   assign out_border = out_valid &&
                       (out_row == RW'(0) || out_row == RW'(IMG_H - 1) ||
                        out_col == CW'(0) || out_col == CW'(IMG_W - 1));

endmodule
